// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of signals between the MIPS pipeline and its hazard controller.
// The pipeline (master) drives the ID/EX observations; the controller (slave) drives the enables.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_instr_rs;
  logic [4:0]       id_instr_rt;
  logic             id_uses_rt;
  logic             id_is_md;
  logic             id_reads_hilo;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_write_reg_addr;
  logic             ex_branch_taken;
  logic             cnt_clear;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;

  modport master (
    output id_instr_rs, id_instr_rt, id_uses_rt, id_is_md, id_reads_hilo,
           id_ex_mem_read, id_ex_write_reg_addr, ex_branch_taken, cnt_clear,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy, md_done,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  id_instr_rs, id_instr_rt, id_uses_rt, id_is_md, id_reads_hilo,
           id_ex_mem_read, id_ex_write_reg_addr, ex_branch_taken, cnt_clear,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy, md_done,
           stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use stall, branch flush,
// multiply/divide busy sequencing and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  localparam logic [7:0]       MD_LOAD = 8'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [7:0]       r_md_cnt;
  logic [7:0]       w_md_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_md_busy;
  logic w_load_use;
  logic w_md_hazard;
  logic w_stall;
  logic w_flush;
  logic w_md_issue;

  assign w_md_busy = (r_state == S_BUSY);
  assign w_flush   = bus.ex_branch_taken;

  // $0 is hard-wired to zero, so a load targeting it can never create a dependency.
  assign w_load_use = bus.id_ex_mem_read && (bus.id_ex_write_reg_addr != 5'd0) &&
                      ((bus.id_ex_write_reg_addr == bus.id_instr_rs) ||
                       (bus.id_uses_rt && (bus.id_ex_write_reg_addr == bus.id_instr_rt)));

  assign w_md_hazard = w_md_busy && (bus.id_is_md || bus.id_reads_hilo);
  assign w_stall     = (w_load_use || w_md_hazard) && !w_flush;
  assign w_md_issue  = bus.id_is_md && !w_md_busy && !w_flush && !w_load_use;

  // Flush wins over stall: wrong-path instructions are squashed, so their hazards are moot.
  assign bus.pc_write     = !w_stall;
  assign bus.if_id_write  = !w_stall;
  assign bus.if_id_flush  = w_flush;
  assign bus.id_ex_bubble = w_flush || w_stall;

  assign bus.md_busy      = w_md_busy;
  assign bus.md_done      = w_md_busy && (r_md_cnt == 8'd0);
  assign bus.stall_cycles = r_stall_cnt;
  assign bus.flush_cycles = r_flush_cnt;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_md_issue) begin
          w_state_nxt  = S_BUSY;
          w_md_cnt_nxt = MD_LOAD;
        end
      end
      S_BUSY: begin
        // A taken branch does not abort the unit; the operation is already in flight.
        if (r_md_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_md_cnt_nxt = r_md_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_md_cnt_nxt = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_md_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Counters stick at all-ones; clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.cnt_clear) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a cycle-level reference model pushes
// expected responses; a monitor on the falling edge pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam int MD_CYCLES = 8;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .MD_CYCLES(MD_CYCLES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_md;
    logic       hilo;
    logic       mem_read;
    logic [4:0] wa;
    logic       br;
    logic       clr;
  } stim_t;

  typedef struct {
    bit    pcw;
    bit    ifw;
    bit    flush;
    bit    bubble;
    bit    busy;
    bit    done;
    int    sc;
    int    fc;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: cycles of occupancy left, and plain integer counters.
  int m_rem = 0;
  int m_sc  = 0;
  int m_fc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '{rs: 5'd0, rt: 5'd0, uses_rt: 1'b0, is_md: 1'b0, hilo: 1'b0,
          mem_read: 1'b0, wa: 5'd0, br: 1'b0, clr: 1'b0};
    return s;
  endfunction

  function automatic stim_t load_use_s(input logic [4:0] r);
    stim_t s;
    s = quiet();
    s.mem_read = 1'b1;
    s.wa       = r;
    s.rs       = r;
    return s;
  endfunction

  // Apply one cycle of stimulus just after the rising edge and predict that cycle.
  task automatic step(input stim_t s, input bit rst, input string tag);
    exp_t e;
    bit   lu, busy, st, issue;
    @(posedge clk);
    #1;
    rst_n                    = !rst;
    bus.id_instr_rs          = s.rs;
    bus.id_instr_rt          = s.rt;
    bus.id_uses_rt           = s.uses_rt;
    bus.id_is_md             = s.is_md;
    bus.id_reads_hilo        = s.hilo;
    bus.id_ex_mem_read       = s.mem_read;
    bus.id_ex_write_reg_addr = s.wa;
    bus.ex_branch_taken      = s.br;
    bus.cnt_clear            = s.clr;
    if (rst) begin
      m_rem = 0;
      m_sc  = 0;
      m_fc  = 0;
    end
    busy  = (m_rem > 0);
    lu    = s.mem_read && (s.wa != 0) && ((s.wa == s.rs) || (s.uses_rt && s.wa == s.rt));
    st    = (lu || (busy && (s.is_md || s.hilo))) && !s.br;
    issue = s.is_md && !busy && !s.br && !lu;
    e.pcw    = !st;
    e.ifw    = !st;
    e.flush  = s.br;
    e.bubble = s.br || st;
    e.busy   = busy;
    e.done   = (m_rem == 1);
    e.sc     = m_sc;
    e.fc     = m_fc;
    e.tag    = tag;
    q.push_back(e);
    if (!rst) begin
      if (m_rem > 0) m_rem--;
      else if (issue) m_rem = MD_CYCLES;
      if (s.clr) begin
        m_sc = 0;
        m_fc = 0;
      end else begin
        if (st && m_sc < CNT_MAX) m_sc++;
        if (s.br && m_fc < CNT_MAX) m_fc++;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".pc_write"},     bus.pc_write,     e.pcw);
        check({e.tag, ".if_id_write"},  bus.if_id_write,  e.ifw);
        check({e.tag, ".if_id_flush"},  bus.if_id_flush,  e.flush);
        check({e.tag, ".id_ex_bubble"}, bus.id_ex_bubble, e.bubble);
        check({e.tag, ".md_busy"},      bus.md_busy,      e.busy);
        check({e.tag, ".md_done"},      bus.md_done,      e.done);
        check({e.tag, ".stall_cycles"}, bus.stall_cycles, e.sc);
        check({e.tag, ".flush_cycles"}, bus.flush_cycles, e.fc);
      end
    end
  end

  initial begin : driver
    stim_t s;
    bus.id_instr_rs          = '0;
    bus.id_instr_rt          = '0;
    bus.id_uses_rt           = 1'b0;
    bus.id_is_md             = 1'b0;
    bus.id_reads_hilo        = 1'b0;
    bus.id_ex_mem_read       = 1'b0;
    bus.id_ex_write_reg_addr = '0;
    bus.ex_branch_taken      = 1'b0;
    bus.cnt_clear            = 1'b0;

    step(quiet(), 1'b1, "reset");
    step(quiet(), 1'b1, "reset");
    step(quiet(), 1'b0, "idle");

    // Load-use on rs, then the bubble clears the load.
    step(load_use_s(5'd5), 1'b0, "lu_rs");
    step(quiet(), 1'b0, "lu_after");
    s = quiet(); s.mem_read = 1'b1; s.wa = 5'd5; s.rt = 5'd5; s.uses_rt = 1'b0;
    step(s, 1'b0, "lu_rt_unused");
    s.uses_rt = 1'b1;
    step(s, 1'b0, "lu_rt_used");
    step(load_use_s(5'd0), 1'b0, "lu_r0");

    // Branch overrides a load-use stall.
    s = load_use_s(5'd7); s.br = 1'b1;
    step(s, 1'b0, "br_vs_lu");

    // mult at T, then mfhi waits through md_done and advances at T+9.
    s = quiet(); s.is_md = 1'b1;
    step(s, 1'b0, "mult_issue");
    s = quiet(); s.hilo = 1'b1;
    for (int i = 1; i <= MD_CYCLES + 1; i++) step(s, 1'b0, $sformatf("mfhi_T%0d", i));

    // Back-to-back mult: second one stalls, then re-issues in the first idle cycle.
    s = quiet(); s.is_md = 1'b1;
    step(s, 1'b0, "b2b_T0");
    for (int i = 1; i <= MD_CYCLES + 1; i++) step(s, 1'b0, $sformatf("b2b_T%0d", i));
    for (int i = 0; i < MD_CYCLES + 1; i++) step(quiet(), 1'b0, "b2b_drain");

    // Reset in the middle of BUSY, then mfhi proceeds immediately.
    s = quiet(); s.is_md = 1'b1;
    step(s, 1'b0, "rst_issue");
    for (int i = 0; i < 3; i++) step(quiet(), 1'b0, "rst_busy");
    step(quiet(), 1'b1, "rst_mid_busy");
    s = quiet(); s.hilo = 1'b1;
    step(s, 1'b0, "rst_mfhi");

    // Saturation at all-ones, then clear together with a stall.
    for (int i = 0; i < 20; i++) step(load_use_s(5'd3), 1'b0, "sat");
    s = load_use_s(5'd3); s.clr = 1'b1;
    step(s, 1'b0, "clr_with_stall");
    step(quiet(), 1'b0, "after_clr");

    // Random traffic with a narrow register range so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.wa       = 5'($urandom_range(0, 3));
      s.uses_rt  = 1'($urandom_range(0, 1));
      s.mem_read = ($urandom_range(0, 99) < 30);
      s.is_md    = ($urandom_range(0, 99) < 20);
      s.hilo     = ($urandom_range(0, 99) < 20);
      s.br       = ($urandom_range(0, 99) < 15);
      s.clr      = ($urandom_range(0, 99) < 3);
      step(s, ($urandom_range(0, 199) == 0), "rand");
    end

    step(quiet(), 1'b0, "final");
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding logic and decides, every cycle, whether IF/ID advance, stall or flush. It detects load-use hazards that forwarding cannot cover and squashes wrong-path instructions on a taken branch. It sequences a multi-cycle multiply/divide unit with a busy-state FSM, and keeps saturating stall/flush performance counters.

## Interface
- MD_CYCLES, 8, multiply/divide occupancy in cycles after issue; legal range 2..255
- CNT_W, 16, width of the performance counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_instr_rs  in  5  rs field of the instruction in ID
- id_instr_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_is_md  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_write_reg_addr  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
- cnt_clear  in  1  synchronous clear of both performance counters
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  zero the IF/ID register on the next edge
- id_ex_bubble  out  1  load a NOP (all control zero) into ID/EX on the next edge
- md_busy  out  1  multiply/divide unit occupied
- md_done  out  1  final occupied cycle of the multiply/divide unit
- stall_cycles  out  CNT_W  count of stalled cycles
- flush_cycles  out  CNT_W  count of flush cycles

## Operation
- load_use = id_ex_mem_read && id_ex_write_reg_addr != 0 && (id_ex_write_reg_addr == id_instr_rs || (id_uses_rt && id_ex_write_reg_addr == id_instr_rt)).
- md_hazard = md_busy && (id_is_md || id_reads_hilo).
- stall = (load_use || md_hazard) && !ex_branch_taken.
- Priority: flush, then stall, then run.
  - Flush (ex_branch_taken=1): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. Any stall condition is ignored.
  - Stall: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1.
  - Run: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- md_issue = id_is_md && !md_busy && !ex_branch_taken && !load_use. The instruction leaves ID this cycle.
- FSM states:
  - IDLE: md_busy=0. On md_issue, go to BUSY and load md_cnt = MD_CYCLES-1.
  - BUSY: md_busy=1. md_cnt decrements each cycle. md_done=1 when md_cnt==0, and on that edge the FSM returns to IDLE.
  - md_cnt is 8 bits.
- A mult/div or mfhi/mflo waiting in ID during BUSY stalls through the md_done cycle. It proceeds in the first IDLE cycle, so back-to-back mult/div ops are never overlapped.
- A taken branch does not abort BUSY; the counter keeps running.
- Counters:
  - stall_cycles increments on each cycle with stall=1.
  - flush_cycles increments on each cycle with ex_branch_taken=1.
  - Both saturate at all-ones and do not wrap.
  - cnt_clear=1 zeroes both on the next edge and has priority over increment.

## Timing
- Control outputs (pc_write, if_id_write, if_id_flush, id_ex_bubble, md_done) are combinational from the inputs and current state. There is no added latency; they are valid within the same cycle.
- md_busy, FSM state, md_cnt and both counters are registered.
- Reset (rst_n=0, asynchronous, also mid-BUSY): state=IDLE, md_cnt=0, md_busy=0, md_done=0, stall_cycles=0, flush_cycles=0.
- With quiescent inputs during reset: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- Multiply/divide latency: issue in cycle T, then md_busy=1 for cycles T+1..T+MD_CYCLES, with md_done=1 in cycle T+MD_CYCLES. A dependent mfhi in ID advances in cycle T+MD_CYCLES+1.
- A load-use stall lasts exactly one cycle. The bubble clears id_ex_mem_read, so there is no second stall.
- A destination of $0 never causes a stall.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_write_reg_addr=5, id_instr_rs=5 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle, stall_cycles 0->1. Repeat with rt=5, id_uses_rt=0 -> no stall. Repeat with address 0 -> no stall.
- Branch vs. stall: load_use condition and ex_branch_taken=1 together -> if_id_flush=1, id_ex_bubble=1, pc_write=1, flush_cycles +1, stall_cycles unchanged.
- Mult then mfhi with MD_CYCLES=8: id_is_md=1 issues at T, then id_reads_hilo=1 -> md_busy high for T+1..T+8, md_done only at T+8, stall for 8 cycles, pc_write=1 again at T+9.
- Back-to-back mult: second id_is_md arrives at T+1 -> stalls until T+9, then re-enters BUSY at T+10.
- Reset mid-BUSY: rst_n=0 at T+4 -> md_busy=0 and counters=0 immediately. After release, mfhi in ID -> no stall.
- Counter saturation with CNT_W=4: 20 stall cycles -> stall_cycles holds 15. cnt_clear=1 together with a stall -> 0 on the next edge.
